// File: rtl/jpeg_pkg.sv
// ---------------------------------------------------------------------------
// jpeg_pkg
// Shared constants and types for the JPEG entropy-coded stream back end.
//   JPEG_ACC_W        bit accumulator width of the packer
//   JPEG_MAX_CODE_W   widest legal Huffman codeword
//   JPEG_LEN_W        width of the codeword length field
//   JPEG_CNT_W        width of the accumulator fill counter (0..64)
//   JPEG_MARKER_BYTE  byte value that must be followed by a stuff byte
//   JPEG_STUFF_BYTE   byte inserted after every marker-valued data byte
//   pk_state_t        bit packer FSM states
// ---------------------------------------------------------------------------
package jpeg_pkg;

    localparam int JPEG_ACC_W      = 64;
    localparam int JPEG_MAX_CODE_W = 27;
    localparam int JPEG_LEN_W      = 5;
    localparam int JPEG_CNT_W      = 7;

    // Highest fill level at which a maximum-width codeword still fits.
    localparam int JPEG_IN_READY_MAX = JPEG_ACC_W - JPEG_MAX_CODE_W;

    localparam logic [7:0] JPEG_MARKER_BYTE = 8'hFF;
    localparam logic [7:0] JPEG_STUFF_BYTE  = 8'h00;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STUFF = 2'd1,
        ST_FLUSH = 2'd2
    } pk_state_t;

    // Illegal lengths above the codeword width are treated as full width.
    function automatic logic [JPEG_LEN_W-1:0] clamp_len(input logic [JPEG_LEN_W-1:0] len);
        if (len > JPEG_LEN_W'(JPEG_MAX_CODE_W)) begin
            return JPEG_LEN_W'(JPEG_MAX_CODE_W);
        end
        return len;
    endfunction

endpackage

// File: rtl/jpeg_bit_merge.sv
// ---------------------------------------------------------------------------
// jpeg_bit_merge
// Combinational accumulator update for the bit packer: optionally drops the
// head byte, then ORs a masked, left-aligned codeword in right after the
// valid bits that remain.
//   acc        current accumulator, MSB = oldest bit, bits below fill are 0
//   pop        head byte leaves this cycle (shift left by 8)
//   ins_pos    fill level after the pop; new bits start at this offset
//   push       a codeword is appended this cycle
//   code       codeword, left-aligned at the MSB, low bits are don't-care
//   length     number of valid codeword bits (already clamped)
//   acc_merged resulting accumulator
// ---------------------------------------------------------------------------
module jpeg_bit_merge
    import jpeg_pkg::*;
(
    input  logic [JPEG_ACC_W-1:0]      acc,
    input  logic                       pop,
    input  logic [JPEG_CNT_W-1:0]      ins_pos,
    input  logic                       push,
    input  logic [JPEG_MAX_CODE_W-1:0] code,
    input  logic [JPEG_LEN_W-1:0]      length,
    output logic [JPEG_ACC_W-1:0]      acc_merged
);

    logic [JPEG_MAX_CODE_W-1:0] code_mask;
    logic [JPEG_MAX_CODE_W-1:0] code_clean;
    logic [JPEG_ACC_W-1:0]      code_top;
    logic [JPEG_ACC_W-1:0]      code_placed;
    logic [JPEG_ACC_W-1:0]      acc_shifted;

    // Bit gi of the codeword is kept when its rank counted from the MSB
    // (1-based) does not exceed the length.
    genvar gi;
    for (gi = 0; gi < JPEG_MAX_CODE_W; gi++) begin : g_mask
        localparam logic [JPEG_LEN_W-1:0] RANK = JPEG_LEN_W'(JPEG_MAX_CODE_W - gi);
        assign code_mask[gi] = (length >= RANK);
    end

    assign code_clean  = code & code_mask;
    assign code_top    = {code_clean, {(JPEG_ACC_W - JPEG_MAX_CODE_W){1'b0}}};
    assign code_placed = code_top >> ins_pos;

    assign acc_shifted = pop ? {acc[JPEG_ACC_W-9:0], 8'h00} : acc;
    assign acc_merged  = push ? (acc_shifted | code_placed) : acc_shifted;

endmodule

// File: rtl/jpeg_bit_packer.sv
// ---------------------------------------------------------------------------
// jpeg_bit_packer
// Packs variable-length Huffman codewords MSB-first into a JPEG
// entropy-coded byte stream, inserting a 0x00 after every 0xFF data byte.
// A flush pads the last partial byte with 1s, drains everything and then
// pulses done.
//   clk, rst       clock, synchronous active-high reset
//   code_in_valid  codeword strobe (accepted with in_ready)
//   code, length   left-aligned codeword and its bit count (0..27)
//   eob_in         codeword closes an 8x8 block (counted in blk_cnt)
//   flush          end-of-scan request (accepted with in_ready)
//   in_ready       packer can take a codeword / flush this cycle
//   out_valid, out_data, out_ready   byte stream handshake
//   done           one-cycle pulse when a flush has completed
//   blk_cnt        number of accepted eob_in codewords, wrapping
// ---------------------------------------------------------------------------
module jpeg_bit_packer
    import jpeg_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       code_in_valid,
    input  logic [JPEG_MAX_CODE_W-1:0] code,
    input  logic [JPEG_LEN_W-1:0]      length,
    input  logic                       eob_in,
    input  logic                       flush,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    input  logic                       out_ready,
    output logic                       done,
    output logic [15:0]                blk_cnt
);

    pk_state_t              state_reg, state_next;
    logic                   flush_pend_reg, flush_pend_next;
    logic [JPEG_ACC_W-1:0]  acc_reg, acc_next;
    logic [JPEG_CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [15:0]            blk_cnt_reg, blk_cnt_next;

    logic [JPEG_LEN_W-1:0]  len_c;
    logic                   push;
    logic                   flush_acc;
    logic                   byte_pop;
    logic [7:0]             head_byte;
    logic [7:0]             pad_mask;
    logic [JPEG_CNT_W-1:0]  pop_bits;
    logic [JPEG_CNT_W-1:0]  ins_pos;
    logic [JPEG_ACC_W-1:0]  acc_merged;

    assign len_c     = clamp_len(length);
    assign head_byte = acc_reg[JPEG_ACC_W-1 -: 8];

    // Bits below the fill level of a partial byte become 1s on flush.
    assign pad_mask  = 8'hFF >> bit_cnt_reg[2:0];

    // Uses the registered count only; a same-cycle pop is not credited, so
    // the worst case 37 + 27 exactly fills the accumulator. A pending flush
    // (including the stuff byte on the way into FLUSH) blocks new input.
    assign in_ready  = (state_reg != ST_FLUSH) && !flush_pend_reg &&
                       (bit_cnt_reg <= JPEG_CNT_W'(JPEG_IN_READY_MAX));
    assign push      = code_in_valid & in_ready;
    assign flush_acc = flush & in_ready;

    // ---------------------------------------------------------------------
    // FSM next-state and output decode
    // ---------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        flush_pend_next = flush_pend_reg | flush_acc;
        out_valid       = 1'b0;
        out_data        = head_byte;
        done            = 1'b0;
        byte_pop        = 1'b0;

        unique case (state_reg)
            ST_RUN: begin
                out_valid = (bit_cnt_reg >= JPEG_CNT_W'(8));
                byte_pop  = out_valid & out_ready;
                if (byte_pop && (head_byte == JPEG_MARKER_BYTE)) begin
                    state_next = ST_STUFF;
                end else if (flush_acc) begin
                    state_next = ST_FLUSH;
                end
            end

            ST_STUFF: begin
                out_valid = 1'b1;
                out_data  = JPEG_STUFF_BYTE;
                if (out_ready) begin
                    state_next = flush_pend_next ? ST_FLUSH : ST_RUN;
                end
            end

            ST_FLUSH: begin
                if (bit_cnt_reg == '0) begin
                    done            = 1'b1;
                    flush_pend_next = 1'b0;
                    state_next      = ST_RUN;
                end else begin
                    out_valid = 1'b1;
                    if (bit_cnt_reg < JPEG_CNT_W'(8)) begin
                        out_data = head_byte | pad_mask;
                    end
                    byte_pop = out_ready;
                    if (byte_pop && (out_data == JPEG_MARKER_BYTE)) begin
                        state_next = ST_STUFF;
                    end
                end
            end

            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Accumulator, fill count and block counter
    // ---------------------------------------------------------------------
    // A padded partial byte consumes all remaining bits; otherwise a pop
    // removes exactly 8. Pushes never coincide with a partial pop because
    // in_ready is low in FLUSH.
    always_comb begin
        pop_bits = '0;
        if (byte_pop) begin
            pop_bits = (bit_cnt_reg < JPEG_CNT_W'(8)) ? bit_cnt_reg : JPEG_CNT_W'(8);
        end
    end

    assign ins_pos      = bit_cnt_reg - pop_bits;
    assign bit_cnt_next = ins_pos + (push ? JPEG_CNT_W'(len_c) : JPEG_CNT_W'(0));
    assign blk_cnt_next = blk_cnt_reg + ((push && eob_in) ? 16'd1 : 16'd0);

    jpeg_bit_merge u_merge (
        .acc        (acc_reg),
        .pop        (byte_pop),
        .ins_pos    (ins_pos),
        .push       (push),
        .code       (code),
        .length     (len_c),
        .acc_merged (acc_merged)
    );

    // Completing a flush leaves a clean, empty accumulator.
    assign acc_next = done ? '0 : acc_merged;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_RUN;
            flush_pend_reg <= 1'b0;
            acc_reg        <= '0;
            bit_cnt_reg    <= '0;
            blk_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            flush_pend_reg <= flush_pend_next;
            acc_reg        <= acc_next;
            bit_cnt_reg    <= bit_cnt_next;
            blk_cnt_reg    <= blk_cnt_next;
        end
    end

    assign blk_cnt = blk_cnt_reg;

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// ---------------------------------------------------------------------------
// tb_jpeg_bit_packer
// Self-checking bench for jpeg_bit_packer. The reference model keeps the
// stream as a queue of bits and derives the expected bytes (with 0xFF/0x00
// stuffing and 1-padding on flush) from it; a negedge monitor collects the
// bytes actually emitted and checks that a stalled byte is held.
// ---------------------------------------------------------------------------
module tb_jpeg_bit_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        code_in_valid = 1'b0;
    logic [26:0] code = '0;
    logic [4:0]  length = '0;
    logic        eob_in = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        done;
    logic [15:0] blk_cnt;

    always #5 clk = ~clk;

    jpeg_bit_packer dut (
        .clk           (clk),
        .rst           (rst),
        .code_in_valid (code_in_valid),
        .code          (code),
        .length        (length),
        .eob_in        (eob_in),
        .flush         (flush),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .done          (done),
        .blk_cnt       (blk_cnt)
    );

    int         nvec = 0;
    int         nerr = 0;
    int         done_cnt = 0;
    int         model_blk = 0;
    int         model_flushes = 0;
    bit         bp_rand = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    bit         mbits[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                nvec++;
                if (!out_valid || out_data !== prev_data) begin
                    nerr++;
                    $display("FAIL hold_stable: out_valid=%0b out_data=%02h, required 1 / %02h",
                             out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (done) done_cnt++;
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
        end
    end

    // Random backpressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_emit(input logic [7:0] b);
        exp_q.push_back(b);
        if (b == 8'hFF) exp_q.push_back(8'h00);
    endtask

    task automatic model_push(input logic [26:0] c, input int len);
        logic [7:0] b;
        for (int i = 0; i < len; i++) mbits.push_back(c[26-i]);
        while (mbits.size() >= 8) begin
            b = '0;
            for (int k = 0; k < 8; k++) b = {b[6:0], mbits.pop_front()};
            model_emit(b);
        end
    endtask

    task automatic model_flush();
        logic [7:0] b;
        if (mbits.size() > 0) begin
            while (mbits.size() < 8) mbits.push_back(1'b1);
            b = '0;
            for (int k = 0; k < 8; k++) b = {b[6:0], mbits.pop_front()};
            model_emit(b);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a codeword and/or flush, waits for in_ready, updates the model.
    task automatic drive(input logic v, input logic [26:0] c, input logic [4:0] len,
                         input logic e, input logic fl);
        int waitc = 0;
        if (len > 5'd27) begin
            $display("FAIL length_legal: length=%0d, required <= 27", len);
            $fatal(1, "illegal length");
        end
        code_in_valid = v;
        code          = c;
        length        = len;
        eob_in        = e;
        flush         = fl;
        while (!in_ready && waitc < 500) begin
            step();
            waitc++;
        end
        if (!in_ready) begin
            nvec++;
            nerr++;
            $display("FAIL in_ready_timeout: in_ready=0 after %0d cycles, required 1", waitc);
        end else begin
            step();
            if (v) begin
                model_push(c, int'(len));
                if (e) model_blk++;
            end
            if (fl) begin
                model_flush();
                model_flushes++;
            end
            $display("xfer valid=%0b code=%07h len=%0d eob=%0b flush=%0b", v, c, len, e, fl);
        end
        code_in_valid = 1'b0;
        flush         = 1'b0;
        eob_in        = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int waitc = 0;
        while (done_cnt < target && waitc < 5000) begin
            step();
            waitc++;
        end
        if (done_cnt < target) begin
            nvec++;
            nerr++;
            $display("FAIL done_timeout: done pulses=%0d, required %0d", done_cnt, target);
        end
    endtask

    function automatic logic [26:0] rnd_code();
        logic [31:0] r;
        r = $urandom;
        return r[26:0];
    endfunction

    task automatic clear_queues();
        got_q.delete();
        exp_q.delete();
        mbits.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        nvec++; if (out_data !== 8'h00) begin nerr++; $display("FAIL reset_out_data: got %02h required 00", out_data); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %0b required 0", done); end
        nvec++; if (blk_cnt !== 16'd0) begin nerr++; $display("FAIL reset_blk_cnt: got %0d required 0", blk_cnt); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    endtask

    task automatic test_byte_assembly();
        logic [26:0] r;
        clear_queues();
        out_ready = 1'b1;
        r = rnd_code();
        drive(1'b1, {4'b1010, r[22:0]}, 5'd4, 1'b0, 1'b0);
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL asm_half: out_valid=%0b required 0", out_valid); end
        r = rnd_code();
        drive(1'b1, {4'b1100, r[22:0]}, 5'd4, 1'b0, 1'b0);
        nvec++; if (out_valid !== 1'b1 || out_data !== 8'hAC) begin
            nerr++; $display("FAIL asm_byte: valid=%0b data=%02h required 1 / AC", out_valid, out_data);
        end
        step();
        nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++; $display("FAIL asm_empty: valid=%0b in_ready=%0b required 0 / 1", out_valid, in_ready);
        end
        nvec++; if (got_q.size() != 1 || got_q[0] !== 8'hAC) begin
            nerr++; $display("FAIL asm_stream: %0d bytes first=%02h required 1 byte AC", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00);
        end
    endtask

    task automatic test_ff_stuffing();
        logic [26:0] r;
        clear_queues();
        out_ready = 1'b1;
        r = rnd_code();
        drive(1'b1, {8'hFF, r[18:0]}, 5'd8, 1'b0, 1'b0);
        nvec++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
            nerr++; $display("FAIL stuff_ff: valid=%0b data=%02h required 1 / FF", out_valid, out_data);
        end
        step();
        nvec++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin
            nerr++; $display("FAIL stuff_00: valid=%0b data=%02h required 1 / 00", out_valid, out_data);
        end
        step();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL stuff_end: valid=%0b required 0", out_valid); end
        nvec++; if (got_q.size() != 2) begin nerr++; $display("FAIL stuff_count: got %0d bytes required 2", got_q.size()); end
    endtask

    task automatic test_flush_padding();
        logic [26:0] r;
        int d0;
        clear_queues();
        out_ready = 1'b1;
        d0 = done_cnt;
        r = rnd_code();
        drive(1'b1, {3'b010, r[23:0]}, 5'd3, 1'b0, 1'b0);
        drive(1'b0, '0, 5'd0, 1'b0, 1'b1);
        nvec++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h5F) begin
            nerr++; $display("FAIL pad_byte: in_ready=%0b valid=%0b data=%02h required 0 / 1 / 5F", in_ready, out_valid, out_data);
        end
        step();
        nvec++; if (done !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            nerr++; $display("FAIL pad_done: done=%0b in_ready=%0b valid=%0b required 1 / 0 / 0", done, in_ready, out_valid);
        end
        step();
        nvec++; if (done !== 1'b0 || in_ready !== 1'b1) begin
            nerr++; $display("FAIL pad_after: done=%0b in_ready=%0b required 0 / 1", done, in_ready);
        end
        nvec++; if (done_cnt - d0 != 1) begin nerr++; $display("FAIL pad_done_count: got %0d required 1", done_cnt - d0); end
    endtask

    task automatic test_pad_ff_and_empty();
        logic [26:0] r;
        clear_queues();
        out_ready = 1'b1;
        r = rnd_code();
        drive(1'b1, {3'b111, r[23:0]}, 5'd3, 1'b0, 1'b0);
        drive(1'b0, '0, 5'd0, 1'b0, 1'b1);
        nvec++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
            nerr++; $display("FAIL padff_byte: valid=%0b data=%02h required 1 / FF", out_valid, out_data);
        end
        step();
        nvec++; if (out_valid !== 1'b1 || out_data !== 8'h00 || in_ready !== 1'b0) begin
            nerr++; $display("FAIL padff_stuff: valid=%0b data=%02h in_ready=%0b required 1 / 00 / 0", out_valid, out_data, in_ready);
        end
        step();
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL padff_done: done=%0b required 1", done); end
        step();
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL padff_ready: in_ready=%0b required 1", in_ready); end
        // Empty flush: done the next cycle, no bytes.
        got_q.delete();
        drive(1'b0, '0, 5'd0, 1'b0, 1'b1);
        nvec++; if (done !== 1'b1 || out_valid !== 1'b0) begin
            nerr++; $display("FAIL empty_flush: done=%0b valid=%0b required 1 / 0", done, out_valid);
        end
        step();
        nvec++; if (got_q.size() != 0) begin nerr++; $display("FAIL empty_bytes: got %0d bytes required 0", got_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [26:0] c1, c2;
        int waitc;
        clear_queues();
        out_ready = 1'b0;
        c1 = rnd_code();
        c2 = rnd_code();
        drive(1'b1, c1, 5'd27, 1'b0, 1'b0);
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready27: in_ready=%0b required 1", in_ready); end
        drive(1'b1, c2, 5'd27, 1'b0, 1'b0);
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready54: in_ready=%0b required 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            nvec++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                nerr++; $display("FAIL bp_head[%0d]: valid=%0b data=%02h required 1 / %02h", i, out_valid, out_data, exp_q[0]);
            end
            step();
        end
        out_ready = 1'b1;
        waitc = 0;
        while ((got_q.size() < exp_q.size() || out_valid) && waitc < 200) begin
            step();
            waitc++;
        end
        nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nerr++; $display("FAIL bp_drained: in_ready=%0b valid=%0b required 1 / 0", in_ready, out_valid);
        end
        drive(1'b0, '0, 5'd0, 1'b0, 1'b1);
        wait_done(done_cnt + 1);
        step();
        nvec++; if (got_q.size() != exp_q.size()) begin
            nerr++; $display("FAIL bp_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            nvec++; if (got_q[i] !== exp_q[i]) begin
                nerr++; $display("FAIL bp_byte[%0d]: got %02h required %02h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [26:0] r;
        clear_queues();
        out_ready = 1'b1;
        r = rnd_code();
        drive(1'b1, {8'hFF, r[18:0]}, 5'd8, 1'b0, 1'b0);
        drive(1'b1, rnd_code(), 5'd20, 1'b1, 1'b0);
        out_ready = 1'b0;
        nvec++; if (out_valid !== 1'b1 || out_data !== 8'h00 || blk_cnt === 16'd0) begin
            nerr++; $display("FAIL mid_stuff_state: valid=%0b data=%02h blk_cnt=%0d required 1 / 00 / nonzero", out_valid, out_data, blk_cnt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || blk_cnt !== 16'd0) begin
            nerr++; $display("FAIL mid_reset: valid=%0b in_ready=%0b blk_cnt=%0d required 0 / 1 / 0", out_valid, in_ready, blk_cnt);
        end
        clear_queues();
        model_blk = 0;
        out_ready = 1'b1;
        repeat (10) step();
        nvec++; if (got_q.size() != 0) begin nerr++; $display("FAIL mid_no_stuff: got %0d bytes required 0", got_q.size()); end
        for (int i = 0; i < 3; i++) drive(1'b1, rnd_code(), 5'($urandom_range(1, 27)), 1'b1, 1'b0);
        nvec++; if (blk_cnt !== 16'd3) begin nerr++; $display("FAIL blk_cnt3: got %0d required 3", blk_cnt); end
        drive(1'b0, '0, 5'd0, 1'b0, 1'b1);
        wait_done(done_cnt + 1);
        step();
        nvec++; if (got_q.size() != exp_q.size()) begin
            nerr++; $display("FAIL mid_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            nvec++; if (got_q[i] !== exp_q[i]) begin
                nerr++; $display("FAIL mid_byte[%0d]: got %02h required %02h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int d0, f0, r;
        clear_queues();
        d0 = done_cnt;
        f0 = model_flushes;
        bp_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                drive(1'b0, '0, 5'd0, 1'b0, 1'b1);
            end else if (r == 1) begin
                drive(1'b1, rnd_code(), 5'($urandom_range(0, 27)), 1'($urandom_range(0, 1)), 1'b1);
            end else if (r < 4) begin
                step();
            end else begin
                drive(1'b1, rnd_code(), 5'($urandom_range(0, 27)), ($urandom_range(0, 7) == 0), 1'b0);
            end
        end
        drive(1'b0, '0, 5'd0, 1'b0, 1'b1);
        bp_rand = 1'b0;
        step();
        out_ready = 1'b1;
        wait_done(d0 + (model_flushes - f0));
        step();
        nvec++; if (done_cnt - d0 != model_flushes - f0) begin
            nerr++; $display("FAIL rnd_done_count: got %0d required %0d", done_cnt - d0, model_flushes - f0);
        end
        nvec++; if (blk_cnt !== 16'(model_blk)) begin
            nerr++; $display("FAIL rnd_blk_cnt: got %0d required %0d", blk_cnt, model_blk);
        end
        nvec++; if (got_q.size() != exp_q.size()) begin
            nerr++; $display("FAIL rnd_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            nvec++; if (got_q[i] !== exp_q[i]) begin
                nerr++; $display("FAIL rnd_byte[%0d]: got %02h required %02h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_assembly();
        test_ff_stuffing();
        test_flush_padding();
        test_pad_ff_and_empty();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
